// File: rtl/led_sequencer_pkg.sv
// ============================================================================
// led_sequencer_pkg
// Shared register map, mode encodings, STATUS bits and FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_sequencer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_OVERRUN = 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_prescaler.sv
// ============================================================================
// led_prescaler
// Tick prescaler (TICK_DIV clocks per tick) and step counter (PERIOD+1 ticks).
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] period,
  output logic       step
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_cnt;
  logic [7:0]    step_cnt;
  logic          tick;
  logic          step_wrap;

  assign tick      = enable && (pre_cnt == PRE_LAST);
  // >= keeps the counter bounded if PERIOD is lowered mid-count
  assign step_wrap = (step_cnt >= period);
  assign step      = tick && step_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else if (!enable) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (clear) begin
        step_cnt <= '0;
      end else if (tick) begin
        step_cnt <= step_wrap ? 8'd0 : step_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// led_sequencer
// Config slave plus Avalon-MM master that writes timed LED frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int         TICK_DIV = 50000,
  parameter logic [3:0] LED_ADDR = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] slave_address,
  input  logic       slave_read,
  input  logic       slave_write,
  input  logic [7:0] slave_writedata,
  output logic [7:0] slave_readdata,
  output logic [3:0] master_address,
  output logic       master_write,
  output logic [7:0] master_writedata,
  input  logic       master_waitrequest
);

  logic [2:0] ctrl;
  logic [7:0] pattern;
  logic [7:0] period;
  logic       overrun;
  logic [7:0] frame;
  logic       dir_right;
  logic       pending;
  state_t     state;

  logic       enable;
  mode_t      mode;
  logic       busy;
  logic       wr_ctrl, wr_pattern, wr_period, wr_status;
  logic       reload_on, reload_off, reload;
  logic [7:0] reload_pat;
  logic       step_raw, step_ok, advance, req_write;
  logic [7:0] next_frame;
  logic       next_dir;

  assign enable     = ctrl[0];
  assign mode       = mode_t'(ctrl[2:1]);
  assign busy       = (state == ST_WRITE);
  assign master_address = LED_ADDR;

  assign wr_ctrl    = slave_write && (slave_address == REG_CTRL);
  assign wr_pattern = slave_write && (slave_address == REG_PATTERN);
  assign wr_period  = slave_write && (slave_address == REG_PERIOD);
  assign wr_status  = slave_write && (slave_address == REG_STATUS);

  // Frame only drives the LEDs while enabled; a disabled PATTERN write just stores.
  assign reload_on  = (wr_ctrl && slave_writedata[0]) || (wr_pattern && enable);
  assign reload_off = wr_ctrl && !slave_writedata[0] && enable;
  assign reload     = reload_on || reload_off;
  assign reload_pat = wr_pattern ? slave_writedata : pattern;

  assign step_ok    = step_raw && !slave_write;
  assign advance    = step_ok && !busy;
  assign req_write  = reload || advance;

  led_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (reload_on),
    .period (period),
    .step   (step_raw)
  );

  always_comb begin
    next_frame = frame;
    next_dir   = dir_right;
    if (reload_off) begin
      next_frame = 8'h00;
    end else if (reload_on) begin
      next_frame = reload_pat;
      next_dir   = 1'b0;
    end else if (advance) begin
      case (mode)
        MODE_STATIC: next_frame = pattern;
        MODE_BLINK:  next_frame = (frame != 8'h00) ? 8'h00 : pattern;
        MODE_CHASE:  next_frame = rotl8(frame);
        MODE_BOUNCE: begin
          if (dir_right) begin
            next_frame = rotr8(frame);
            if (next_frame[0]) next_dir = 1'b0;
          end else begin
            next_frame = rotl8(frame);
            if (next_frame[7]) next_dir = 1'b1;
          end
        end
        default: next_frame = frame;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl           <= '0;
      pattern        <= '0;
      period         <= '0;
      overrun        <= 1'b0;
      frame          <= '0;
      dir_right      <= 1'b0;
      slave_readdata <= '0;
    end else begin
      if (wr_ctrl)    ctrl    <= slave_writedata[2:0];
      if (wr_pattern) pattern <= slave_writedata;
      if (wr_period)  period  <= slave_writedata;
      if (wr_status && slave_writedata[STATUS_OVERRUN]) begin
        overrun <= 1'b0;
      end else if (step_ok && busy) begin
        overrun <= 1'b1;
      end
      frame     <= next_frame;
      dir_right <= next_dir;
      if (slave_read) begin
        case (slave_address)
          REG_CTRL:    slave_readdata <= {5'b0, ctrl};
          REG_PATTERN: slave_readdata <= pattern;
          REG_PERIOD:  slave_readdata <= period;
          REG_STATUS:  slave_readdata <= {6'b0, overrun, busy};
          default:     slave_readdata <= '0;
        endcase
      end
    end
  end

  // Master FSM: one outstanding write plus at most one queued reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      master_write     <= 1'b0;
      master_writedata <= '0;
      pending          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_write || pending) begin
            state            <= ST_WRITE;
            master_write     <= 1'b1;
            master_writedata <= next_frame;
            pending          <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (reload) pending <= 1'b1;
          if (!master_waitrequest) begin
            state        <= ST_IDLE;
            master_write <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          master_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// tb_led_sequencer
// Self-checking bench for led_sequencer against a frame-sequence model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_sequencer;

  localparam int         TD   = 4;
  localparam logic [3:0] ADDR = 4'h9;
  localparam int         K    = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] slave_address = '0;
  logic       slave_read = 1'b0;
  logic       slave_write = 1'b0;
  logic [7:0] slave_writedata = '0;
  logic [7:0] slave_readdata;
  logic [3:0] master_address;
  logic       master_write;
  logic [7:0] master_writedata;
  logic       master_waitrequest = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int         cq[$];
  logic [7:0] rdat;

  led_sequencer #(
    .TICK_DIV (TD),
    .LED_ADDR (ADDR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .slave_address      (slave_address),
    .slave_read         (slave_read),
    .slave_write        (slave_write),
    .slave_writedata    (slave_writedata),
    .slave_readdata     (slave_readdata),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  // Log every accepted master write with its cycle index.
  always @(negedge clk) begin
    cyc++;
    if (reset && master_write && !master_waitrequest) begin
      wq.push_back(master_writedata);
      cq.push_back(cyc);
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    step_clk(1);
    slave_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    step_clk(1);
    slave_read    = 1'b0;
    d             = slave_readdata;
  endtask

  function automatic logic [7:0] rot_l(input logic [7:0] v);
    return 8'((int'(v) * 2) % 256 + int'(v) / 128);
  endfunction

  function automatic logic [7:0] rot_r(input logic [7:0] v);
    return 8'(int'(v) / 2 + (int'(v) % 2) * 128);
  endfunction

  initial begin
    // Reset state
    step_clk(3);
    check_value("rst_mwrite", master_write, 0);
    check_value("rst_mdata", master_writedata, 0);
    reset = 1'b1;
    step_clk(1);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rdat);
      check_value($sformatf("rst_reg%0d", a), rdat, 0);
    end

    // Enable in static mode: exactly one write of the pattern
    wq.delete(); cq.delete();
    wr(2'd1, 8'h81);
    wr(2'd0, 8'h01);
    check_value("en_mwrite", master_write, 1);
    check_value("en_mdata", master_writedata, 8'h81);
    check_value("maddr", master_address, ADDR);
    step_clk(1);
    check_value("en_count", wq.size(), 1);
    rd(2'd0, rdat); check_value("rb_ctrl", rdat, 8'h01);
    rd(2'd1, rdat); check_value("rb_pat", rdat, 8'h81);

    // Randomized mode/pattern/period trials against the frame model
    for (int t = 0; t < 8; t++) begin
      logic [1:0] m;
      logic [7:0] pat, per, f;
      logic [7:0] exp_f[K];
      logic       right, on;
      int         budget;
      m   = 2'($urandom_range(3));
      pat = 8'($urandom_range(1, 255));
      per = 8'($urandom_range(0, 3));
      if (t == 0) begin m = 2'd3; pat = 8'h00; end
      if (t == 1) begin m = 2'd2; pat = 8'h01; end
      if (t == 2) begin m = 2'd3; pat = 8'h01; end
      if (t == 3) begin m = 2'd1; pat = 8'h81; per = 8'd1; end
      f = pat; right = 1'b0; on = 1'b1;
      exp_f[0] = pat;
      for (int i = 1; i < K; i++) begin
        case (m)
          2'd0: f = pat;
          2'd1: begin on = !on; f = on ? pat : 8'h00; end
          2'd2: f = rot_l(f);
          default: begin
            if (!right) begin
              f = rot_l(f);
              if (f >= 8'd128) right = 1'b1;
            end else begin
              f = rot_r(f);
              if (f % 2 == 1) right = 1'b0;
            end
          end
        endcase
        exp_f[i] = f;
      end

      wr(2'd0, 8'h00);
      wr(2'd2, per);
      wr(2'd1, pat);
      step_clk(1);
      rd(2'd2, rdat); check_value("rb_period", rdat, per);
      wq.delete(); cq.delete();
      wr(2'd0, {5'b0, m, 1'b1});
      budget = K * TD * (int'(per) + 1) + 20;
      while (wq.size() < K && budget > 0) begin
        step_clk(1);
        budget--;
      end
      check_value($sformatf("t%0d_count", t), wq.size(), K);
      for (int i = 0; i < K && i < wq.size(); i++) begin
        check_value($sformatf("t%0d_frame%0d", t, i), wq[i], exp_f[i]);
        if (i > 0)
          check_value($sformatf("t%0d_gap%0d", t, i), cq[i] - cq[i-1], TD * (int'(per) + 1));
      end
      rd(2'd0, rdat); check_value("rb_ctrl_run", rdat, {5'b0, m, 1'b1});
    end
    wr(2'd0, 8'h00);
    step_clk(2);
    rd(2'd3, rdat); check_value("status_clean", rdat, 8'h00);

    // Stall: data held stable, overrun raised, cleared by write-1
    wr(2'd2, 8'd0);
    wr(2'd1, 8'h5A);
    step_clk(2);
    master_waitrequest = 1'b1;
    wr(2'd0, 8'h01);
    for (int i = 0; i < 20; i++) begin
      check_value("stall_mwrite", master_write, 1);
      check_value("stall_mdata", master_writedata, 8'h5A);
      step_clk(1);
    end
    rd(2'd3, rdat); check_value("stall_status", rdat, 8'h03);
    wr(2'd3, 8'h02);
    rd(2'd3, rdat); check_value("ovr_clear", rdat, 8'h01);
    master_waitrequest = 1'b0;
    step_clk(2);
    wr(2'd0, 8'h00);
    step_clk(2);
    wr(2'd3, 8'h02);

    // Reload during a stalled write: one extra write follows
    wr(2'd2, 8'd255);
    wr(2'd1, 8'h5A);
    master_waitrequest = 1'b1;
    wr(2'd0, 8'h01);
    step_clk(3);
    wq.delete(); cq.delete();
    wr(2'd1, 8'h3C);
    step_clk(3);
    check_value("pend_hold", master_writedata, 8'h5A);
    master_waitrequest = 1'b0;
    step_clk(6);
    check_value("pend_count", wq.size(), 2);
    check_value("pend_w0", (wq.size() > 0) ? wq[0] : 8'hxx, 8'h5A);
    check_value("pend_w1", (wq.size() > 1) ? wq[1] : 8'hxx, 8'h3C);

    // Asynchronous reset in the middle of a write
    master_waitrequest = 1'b1;
    wr(2'd1, 8'h77);
    step_clk(2);
    check_value("pre_rst_mwrite", master_write, 1);
    #2 reset = 1'b0;
    #1;
    check_value("async_rst_mwrite", master_write, 0);
    check_value("async_rst_mdata", master_writedata, 0);
    step_clk(2);
    reset = 1'b1;
    master_waitrequest = 1'b0;
    step_clk(1);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rdat);
      check_value($sformatf("post_rst_reg%0d", a), rdat, 0);
    end
    check_value("post_rst_mwrite", master_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_sequencer.md
# led_sequencer

Avalon-MM controller that drives the 8-bit LED output register of the watch's LED peripheral. Software sets mode, pattern and step period through a small slave port. The block then issues timed single-beat writes to the LED register through its own master port, producing static, blink, chase or bounce patterns without CPU involvement. It sits between the Nios/CPU bus and the LED register slave.

## Interface
- TICK_DIV, default 50000: clk cycles per prescaler tick (1 kHz at 50 MHz); minimum 2.
- LED_ADDR, default 4'b0000: address driven on master_address.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- slave_address  in  2  config register select
- slave_read  in  1  config read strobe
- slave_write  in  1  config write strobe
- slave_writedata  in  8  config write data
- slave_readdata  out  8  config read data, registered
- master_address  out  4  LED register address, constant LED_ADDR
- master_write  out  1  write request to LED register
- master_writedata  out  8  LED frame
- master_waitrequest  in  1  LED slave stall; the write is accepted in the cycle it is low

## Operation
- Registers:
  - 0 CTRL[2:0]: bit0 enable; bits2:1 mode (00 static, 01 blink, 10 chase, 11 bounce).
  - 1 PATTERN.
  - 2 PERIOD: a step occurs every PERIOD+1 ticks.
  - 3 STATUS: bit0 busy (read-only); bit1 overrun (sticky, write 1 to clear).
- Unused bits read 0.
- Reset values: CTRL 0, PATTERN 0, PERIOD 0, STATUS 0, frame 0, direction left, slave_readdata 0, master_write 0, master_writedata 0.
- Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap. Step counter counts ticks 0..PERIOD and emits a step on wrap. Both counters run only while enabled and are cleared when enable=0.
- Frame update on step (enable=1):
  - Static: frame=PATTERN.
  - Blink: frame alternates PATTERN / 8'h00.
  - Chase: frame rotates left by 1.
  - Bounce: rotates in the current direction. Direction flips when the rotated frame has bit7 set (going left) or bit0 set (going right).
- Reload events:
  - A write to CTRL or PATTERN loads frame=PATTERN, resets direction to left and the step counter, and requests a bus write.
  - Clearing enable loads frame=8'h00 and requests a bus write.
- FSM IDLE -> WRITE on a write request. In WRITE, master_write=1 with master_writedata held stable. WRITE -> IDLE in the cycle after master_waitrequest=0.
- busy = (state==WRITE).
- Step while in WRITE: frame is not advanced, overrun is set, and the step is dropped.
- Reload while in WRITE: frame is updated and a pending flag is set. After the current write completes, the FSM returns to WRITE once more with the new frame. Only one pending write is held.
- Config write and step in the same cycle: the config write wins and the step is discarded (no overrun).

## Timing
- Step or reload in cycle N: master_write=1 from N+1.
- With waitrequest=0 at N+1, master_write=0 at N+2. Minimum 2 cycles per frame update.
- slave_readdata is valid in the cycle after slave_read (1-cycle read latency). Slave writes take effect the following cycle. The slave port never stalls.
- Reset low drops master_write immediately, without a clock edge, and returns all state to reset values.
- PATTERN=0 in chase/bounce: frame stays 0, bounce direction does not oscillate spuriously, and writes still occur each step.

## Structure
- Shared package: register offsets, mode encodings, STATUS bit positions, FSM state encoding.
- One sub-module, led_prescaler: tick and step counters with clear input, parameter TICK_DIV and PERIOD input.
- Top level holds the register file, frame/direction logic and the master FSM.

## Test plan
- Reset with TICK_DIV=4, then write PATTERN=8'h81, CTRL=3'b001 -> a single master write of 8'h81 within 2 cycles; all readback values correct.
- Blink mode, PERIOD=1, waitrequest=0 -> writes alternate 8'h81 / 8'h00 exactly every 8 clk cycles.
- Chase with PATTERN=8'h01 -> write sequence 01,02,04,…,80,01. Bounce with the same pattern -> 01,02,…,80,40,…,01,02.
- Hold waitrequest=1 for 20 cycles with TICK_DIV=4, PERIOD=0 -> master_writedata stays stable, STATUS reads 8'h03. Writing STATUS=8'h02 clears overrun.
- Write PATTERN=8'h3C while in WRITE -> the current write completes, then exactly one extra write of 8'h3C follows.
- Assert reset mid-write -> master_write=0 without a clock edge, and all registers read 0 after release.
